// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-stage status (driven by the datapath)
// and stage enable/flush controls plus status (driven by the controller).
interface pipeline_hazard_ctrl_if #(
  parameter int STAT_W = 32
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rt;
  logic              id_jump;
  logic              ex_MemRead;
  logic [4:0]        ex_WriteAddr;
  logic              ex_branch_taken;
  logic              mem_MemRead;
  logic              mem_MemWrite;
  logic              mem_ready;

  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_flush;
  logic              ex_mem_en;
  logic              mem_wb_bubble;
  logic [1:0]        ctrl_state;
  logic              timeout_err;
  logic [STAT_W-1:0] stall_cycles;
  logic [STAT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, ex_MemRead, ex_WriteAddr,
           ex_branch_taken, mem_MemRead, mem_MemWrite, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, ctrl_state, timeout_err, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, ex_MemRead, ex_WriteAddr,
           ex_branch_taken, mem_MemRead, mem_MemWrite, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, ctrl_state, timeout_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls,
// branch/jump flushes, data-memory wait freeze and sticky timeout fault.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN
// is defined; otherwise the statistics outputs are tied to zero.
//
// state    | meaning
// RUN      | normal issue, all hazards evaluated
// LU_STALL | one-cycle load-use bubble, load-use not re-detected
// MEM_WAIT | pipeline frozen until data memory is ready
// ERROR    | memory timeout, pipeline frozen until reset
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STAT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  logic mem_busy, load_use;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;

  assign mem_busy = (hz.mem_MemRead | hz.mem_MemWrite) & ~hz.mem_ready;
  assign load_use = hz.ex_MemRead & (hz.ex_WriteAddr != 5'd0) &
                    ((hz.ex_WriteAddr == hz.id_rs) |
                     (hz.id_uses_rt & (hz.ex_WriteAddr == hz.id_rt)));

  // Next-state and combinational stage controls; reset forces everything idle.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    unique case (state_q)
      RUN, LU_STALL: begin
        if (mem_busy) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
          state_d       = MEM_WAIT;
          wait_cnt_d    = CW'(1);
        end else if (hz.ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = RUN;
        end else if ((state_q == RUN) && load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = LU_STALL;
        end else begin
          if_id_flush = hz.id_jump;
          state_d     = RUN;
        end
      end
      MEM_WAIT: begin
        // Release in the ready cycle itself; no other hazard is evaluated here.
        if (hz.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
          if (wait_cnt_q == TO_CNT) begin
            state_d       = ERROR;
            timeout_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      ERROR: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end
    endcase
    if (reset) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b0;
    end
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign hz.pc_en         = pc_en;
  assign hz.if_id_en      = if_id_en;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_en      = id_ex_en;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.ex_mem_en     = ex_mem_en;
  assign hz.mem_wb_bubble = mem_wb_bubble;
  assign hz.ctrl_state    = state_q;
  assign hz.timeout_err   = timeout_err_q;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  // Saturating stall/flush counters; ERROR-state freeze is not a stall.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && (state_q != ERROR) && (stall_q != {STAT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
    if (if_id_flush && (flush_q != {STAT_W{1'b1}}))
      flush_d = flush_q + 1'b1;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`else
  assign hz.stall_cycles = {STAT_W{1'b0}};
  assign hz.flush_count  = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control vectors are
// queued as each step is driven and compared at the following falling edge.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.STAT_W(32)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .STAT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int vectors = 0;
  int miscompares = 0;
  int stall_m = 0;
  int flush_m = 0;
  logic [9:0] exp_q[$];

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, ctrl_state[1:0], timeout_err}
  localparam logic [9:0] E_RST  = 10'b0000000_00_0;
  localparam logic [9:0] E_IDLE = 10'b1101010_00_0;
  localparam logic [9:0] E_LU   = 10'b0001110_00_0;
  localparam logic [9:0] E_LUS  = 10'b1101010_01_0;
  localparam logic [9:0] E_LUSJ = 10'b1111010_01_0;
  localparam logic [9:0] E_BR   = 10'b1111110_00_0;
  localparam logic [9:0] E_JMP  = 10'b1111010_00_0;
  localparam logic [9:0] E_FRZ0 = 10'b0000001_00_0;
  localparam logic [9:0] E_FRZ2 = 10'b0000001_10_0;
  localparam logic [9:0] E_REL  = 10'b1101010_10_0;
  localparam logic [9:0] E_ERR  = 10'b0000001_11_1;

  task automatic step(input logic [9:0] e, input string tag);
    logic [9:0]  o, x;
    logic [63:0] so, se;
    exp_q.push_back(e);
    @(negedge clk);
    if (reset) begin
      stall_m = 0;
      flush_m = 0;
    end
    o = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
         hz.ex_mem_en, hz.mem_wb_bubble, hz.ctrl_state, hz.timeout_err};
    x = exp_q.pop_front();
    vectors++;
    assert (o === x) else begin
      miscompares++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, o, x);
    end
    so = {hz.stall_cycles, hz.flush_count};
`ifdef HAZARD_STATS_EN
    se = {stall_m[31:0], flush_m[31:0]};
`else
    se = 64'd0;
`endif
    vectors++;
    assert (so === se) else begin
      miscompares++;
      $error("FAIL %s stats observed=%h expected=%h", tag, so, se);
    end
    if (!reset) begin
      if (!x[9] && (x[2:1] != 2'd3)) stall_m++;
      if (x[7]) flush_m++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hz.id_rs = 5'd0;  hz.id_rt = 5'd0;  hz.id_uses_rt = 1'b0;  hz.id_jump = 1'b0;
    hz.ex_MemRead = 1'b0;  hz.ex_WriteAddr = 5'd0;  hz.ex_branch_taken = 1'b0;
    hz.mem_MemRead = 1'b0;  hz.mem_MemWrite = 1'b0;  hz.mem_ready = 1'b0;

    step(E_RST, "reset");
    reset = 1'b0;
    step(E_IDLE, "idle");

    // load-use on rs: one bubble, no second stall
    hz.ex_MemRead = 1'b1;  hz.ex_WriteAddr = 5'd8;  hz.id_rs = 5'd8;
    step(E_LU, "lu_rs");
    step(E_LUS, "lu_no_redetect");
    hz.ex_MemRead = 1'b0;
    step(E_IDLE, "lu_done");

    // rt match only counts when the instruction reads rt
    hz.ex_MemRead = 1'b1;  hz.id_rs = 5'd3;  hz.id_rt = 5'd8;  hz.id_uses_rt = 1'b0;
    step(E_IDLE, "rt_unused");
    hz.id_uses_rt = 1'b1;
    step(E_LU, "lu_rt");
    hz.ex_MemRead = 1'b0;
    step(E_LUS, "lu_rt_bubble");
    step(E_IDLE, "lu_rt_done");

    // taken branch overrides load-use and jump
    hz.ex_MemRead = 1'b1;  hz.ex_branch_taken = 1'b1;  hz.id_jump = 1'b1;
    step(E_BR, "br_over_lu");
    hz.ex_MemRead = 1'b0;  hz.ex_branch_taken = 1'b0;  hz.id_jump = 1'b0;
    step(E_IDLE, "br_no_stall");

    // $zero destination never stalls
    hz.ex_MemRead = 1'b1;  hz.ex_WriteAddr = 5'd0;  hz.id_rs = 5'd0;  hz.id_rt = 5'd0;
    step(E_IDLE, "r0_no_stall");
    hz.ex_MemRead = 1'b0;

    // jump flush; load-use beats jump; jump seen in the bubble cycle
    hz.id_jump = 1'b1;
    step(E_JMP, "jump");
    hz.ex_MemRead = 1'b1;  hz.ex_WriteAddr = 5'd5;  hz.id_rs = 5'd5;
    step(E_LU, "lu_over_jump");
    hz.ex_MemRead = 1'b0;
    step(E_LUSJ, "jump_in_bubble");
    hz.id_jump = 1'b0;
    step(E_IDLE, "jump_done");

    // load completing immediately is not a wait
    hz.mem_MemRead = 1'b1;  hz.mem_ready = 1'b1;
    step(E_IDLE, "ld_fast");
    hz.mem_MemRead = 1'b0;

    // store waiting 3 cycles, released in the 4th; branch ignored on release
    hz.mem_MemWrite = 1'b1;  hz.mem_ready = 1'b0;
    step(E_FRZ0, "sw_wait1");
    step(E_FRZ2, "sw_wait2");
    step(E_FRZ2, "sw_wait3");
    hz.mem_ready = 1'b1;  hz.ex_branch_taken = 1'b1;
    step(E_REL, "sw_release");
    hz.mem_MemWrite = 1'b0;  hz.mem_ready = 1'b0;  hz.ex_branch_taken = 1'b0;
    step(E_IDLE, "sw_after");

    // load never ready: 1 entry cycle + 16 wait cycles, then ERROR
    hz.mem_MemRead = 1'b1;
    step(E_FRZ0, "to_entry");
    for (int i = 0; i < 16; i++) step(E_FRZ2, "to_wait");
    step(E_ERR, "to_error");
    hz.mem_MemRead = 1'b0;  hz.mem_ready = 1'b1;  hz.ex_branch_taken = 1'b1;
    step(E_ERR, "err_sticky");
    hz.mem_ready = 1'b0;  hz.ex_branch_taken = 1'b0;
    reset = 1'b1;
    step(E_RST, "err_reset");
    reset = 1'b0;
    step(E_IDLE, "err_cleared");

    // reset mid-wait aborts asynchronously
    hz.mem_MemRead = 1'b1;
    step(E_FRZ0, "rw_entry");
    step(E_FRZ2, "rw_wait1");
    step(E_FRZ2, "rw_wait2");
    reset = 1'b1;
    step(E_RST, "reset_in_wait");
    hz.mem_MemRead = 1'b0;
    reset = 1'b0;
    step(E_IDLE, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
